// File: rtl/byte_word_packer_pkg.sv
// Shared widths, fill-state encoding and lane placement for the byte-to-word packer.
package byte_word_packer_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_IDX_W     = 2;

    // The byte counter doubles as the packer state: number of lanes already filled.
    typedef enum logic [LANE_IDX_W-1:0] {
        EMPTY = 2'd0,
        PART1 = 2'd1,
        PART2 = 2'd2,
        PART3 = 2'd3
    } fill_state_e;

    function automatic int lane_lsb(input int lane, input bit big_endian);
        return big_endian ? (WORD_W - BYTE_W * (lane + 1)) : (BYTE_W * lane);
    endfunction

endpackage

// File: rtl/byte_word_packer_lane.sv
// One 8-bit byte lane register with load enable and asynchronous active-high reset.
module byte_lane_reg
    import byte_word_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] d_i,
    output logic [BYTE_W-1:0] q_o
);

    logic [BYTE_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words; in_last flushes a partial word with
// unused lanes zeroed. One registered output slot with a valid/ready handshake.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int BIG_ENDIAN = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      out_word,
    output logic [2:0]       out_bcnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    fill_state_e             state_q, state_d;
    logic [LANE_IDX_W-1:0]   fill_idx;
    logic [BYTE_W-1:0]       lane_q [BYTES_PER_WORD];
    logic [BYTES_PER_WORD-1:0] lane_load;

    logic                    in_hs;
    logic                    out_hs;
    logic                    complete;

    logic [WORD_W-1:0]       word_q, word_d;
    logic [2:0]              bcnt_q, bcnt_d;
    logic                    valid_q, valid_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;

    // The output slot can take a new word whenever it is empty or draining this cycle.
    assign in_ready = !valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;
    assign fill_idx = state_q;
    assign complete = in_hs && ((state_q == PART3) || in_last);

    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
        assign lane_load[k] = in_hs && (fill_idx == LANE_IDX_W'(k));

        byte_lane_reg u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (lane_load[k]),
            .d_i    (in_byte),
            .q_o    (lane_q[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_hs) begin
            if (complete) begin
                state_d = EMPTY;
            end else begin
                state_d = fill_state_e'(fill_idx + LANE_IDX_W'(1));
            end
        end
    end

    // The completing byte bypasses its lane so the word is ready one edge after acceptance.
    always_comb begin
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        valid_d = valid_q;
        if (complete) begin
            word_d = '0;
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (LANE_IDX_W'(k) < fill_idx) begin
                    word_d[lane_lsb(k, BIG_ENDIAN != 0) +: BYTE_W] = lane_q[k];
                end else if (LANE_IDX_W'(k) == fill_idx) begin
                    word_d[lane_lsb(k, BIG_ENDIAN != 0) +: BYTE_W] = in_byte;
                end
            end
            bcnt_d  = {1'b0, fill_idx} + 3'd1;
            valid_d = 1'b1;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (out_hs) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign out_word  = word_q;
    assign out_bcnt  = bcnt_q;
    assign out_valid = valid_q;
    assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Drives a little-endian (CNT_W=4) and a big-endian packer with shared stimulus
// and compares both against a byte-queue reference model.
module tb_byte_word_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_le, out_valid_le;
    logic [31:0] out_word_le;
    logic [2:0]  out_bcnt_le;
    logic [3:0]  word_cnt_le;

    logic        in_ready_be, out_valid_be;
    logic [31:0] out_word_be;
    logic [2:0]  out_bcnt_be;
    logic [15:0] word_cnt_be;

    byte_word_packer #(.BIG_ENDIAN(0), .CNT_W(4)) dut_le (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_le), .out_word(out_word_le), .out_bcnt(out_bcnt_le),
        .out_valid(out_valid_le), .out_ready(out_ready), .word_cnt(word_cnt_le)
    );

    byte_word_packer #(.BIG_ENDIAN(1), .CNT_W(16)) dut_be (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_be), .out_word(out_word_be), .out_bcnt(out_bcnt_be),
        .out_valid(out_valid_be), .out_ready(out_ready), .word_cnt(word_cnt_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes collected since the last word, plus the pending output word.
    logic [7:0]  part[$];
    bit          m_valid;
    logic [31:0] m_word_le, m_word_be;
    logic [2:0]  m_bcnt;
    int unsigned m_wcnt;

    task automatic model_reset();
        part.delete();
        m_valid   = 1'b0;
        m_word_le = '0;
        m_word_be = '0;
        m_bcnt    = '0;
        m_wcnt    = 0;
    endtask

    task automatic model_edge(input logic [7:0] b, input bit v, input bit l, input bit r);
        bit rdy, hs;
        rdy = !m_valid || r;
        hs  = m_valid && r;
        if (hs) m_wcnt++;
        if (v && rdy) begin
            part.push_back(b);
            if (part.size() == 4 || l) begin
                m_word_le = '0;
                m_word_be = '0;
                foreach (part[i]) begin
                    m_word_le |= 32'(part[i]) << (8 * i);
                    m_word_be |= 32'(part[i]) << (24 - 8 * i);
                end
                m_bcnt  = 3'(part.size());
                m_valid = 1'b1;
                part.delete();
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outs();
        chk("valid_le", 64'(out_valid_le), 64'(m_valid));
        chk("valid_be", 64'(out_valid_be), 64'(m_valid));
        if (m_valid) begin
            chk("word_le", 64'(out_word_le), 64'(m_word_le));
            chk("bcnt_le", 64'(out_bcnt_le), 64'(m_bcnt));
            chk("word_be", 64'(out_word_be), 64'(m_word_be));
            chk("bcnt_be", 64'(out_bcnt_be), 64'(m_bcnt));
        end
        chk("wcnt_le", 64'(word_cnt_le), 64'(m_wcnt % 16));
        chk("wcnt_be", 64'(word_cnt_be), 64'(m_wcnt % 65536));
    endtask

    // Called just after a falling edge: drive, check ready, clock, check outputs.
    task automatic step(input logic [7:0] b, input bit v, input bit l, input bit r);
        in_byte   = b;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #1;
        chk("in_ready_le", 64'(in_ready_le), 64'(!m_valid || r));
        chk("in_ready_be", 64'(in_ready_be), 64'(!m_valid || r));
        @(posedge clk);
        model_edge(b, v, l, r);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        #1;
        model_reset();
        chk("rst_word_le", 64'(out_word_le), 64'h0);
        chk("rst_bcnt_le", 64'(out_bcnt_le), 64'h0);
        chk("rst_word_be", 64'(out_word_be), 64'h0);
        check_outs();
        chk("rst_ready_le", 64'(in_ready_le), 64'h1);
        chk("rst_ready_be", 64'(in_ready_be), 64'h1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_byte   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Full words in both lane orders.
        step(8'h11, 1, 0, 1); step(8'h22, 1, 0, 1); step(8'h33, 1, 0, 1); step(8'h44, 1, 0, 1);
        chk("ex_le_word", 64'(out_word_le), 64'h44332211);
        chk("ex_le_bcnt", 64'(out_bcnt_le), 64'd4);
        chk("ex_be_word0", 64'(out_word_be), 64'h11223344);
        idle();
        chk("ex_wcnt1", 64'(word_cnt_le), 64'd1);
        step(8'hAA, 1, 0, 1); step(8'hBB, 1, 0, 1); step(8'hCC, 1, 0, 1); step(8'hDD, 1, 0, 1);
        chk("ex_be_word", 64'(out_word_be), 64'hAABBCCDD);
        chk("ex_be_bcnt", 64'(out_bcnt_be), 64'd4);
        idle();

        // Partial flush, then the next byte must start again in lane 0.
        step(8'h5A, 1, 0, 1); step(8'h6B, 1, 1, 1);
        chk("flush_word", 64'(out_word_le), 64'h00006B5A);
        chk("flush_bcnt", 64'(out_bcnt_le), 64'd2);
        step(8'h77, 1, 1, 1);
        chk("lane0_word", 64'(out_word_le), 64'h00000077);
        idle();

        // Backpressure hold, then handshake and completion in the same cycle.
        step(8'h01, 1, 0, 1); step(8'h02, 1, 0, 1); step(8'h03, 1, 0, 1); step(8'h04, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(8'h55, 1, 1, 0);
            chk("hold_word", 64'(out_word_le), 64'h04030201);
        end
        step(8'h55, 1, 1, 1);
        chk("b2b_valid", 64'(out_valid_le), 64'h1);
        chk("b2b_word", 64'(out_word_le), 64'h00000055);
        step(8'h66, 1, 1, 1);
        chk("b2b_word2", 64'(out_word_be), 64'h66000000);
        idle();

        // Reset mid-word discards the partial bytes.
        step(8'hE1, 1, 0, 1); step(8'hE2, 1, 0, 1); step(8'hE3, 1, 0, 1);
        do_reset();
        step(8'h01, 1, 0, 1); step(8'h02, 1, 0, 1); step(8'h03, 1, 0, 1); step(8'h04, 1, 0, 1);
        chk("post_rst_word", 64'(out_word_le), 64'h04030201);

        // Reset with a pending word, then 17 words to wrap the 4-bit counter.
        do_reset();
        for (int w = 0; w < 17; w++) begin
            for (int b = 0; b < 4; b++) step(8'(w * 4 + b), 1, 0, 1);
        end
        idle();
        chk("wrap_le", 64'(word_cnt_le), 64'd1);
        chk("wrap_be", 64'(word_cnt_be), 64'd17);

        for (int i = 0; i < 600; i++) begin
            step(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 3; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
